// File: rtl/cache_pkg.sv
// Shared types for the instruction-cache sequencer.
package cache_pkg;

  typedef enum logic [1:0] {
    StSweep,
    StLookup,
    StMem,
    StFill
  } cache_state_e;

endpackage

// File: rtl/icache_controller.sv
// Sequencer for one direct-mapped, read-only cache set: invalidate sweep,
// zero-wait hit lookup and single-word refill from the memory bus.
module icache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_rd,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_ready,
  input  logic                   i_flush,
  output logic                   o_busy,
  output logic [INDEX_WIDTH-1:0] o_set_index,
  output logic [TAG_WIDTH-1:0]   o_set_tag,
  output logic                   o_set_wr,
  output logic                   o_set_cl,
  output logic [DATA_WIDTH-1:0]  o_set_data,
  input  logic [DATA_WIDTH-1:0]  i_set_data,
  input  logic                   i_set_hit,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic                   o_mem_rd,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  input  logic                   i_mem_ack
);

  localparam int unsigned WordW = ADDR_WIDTH - 2;

  cache_state_e           state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [WordW-1:0]       waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   pend_q, pend_d;

  logic [INDEX_WIDTH-1:0] cpu_index;
  logic [TAG_WIDTH-1:0]   cpu_tag;
  logic [WordW-1:0]       cpu_waddr;

  assign cpu_index = INDEX_WIDTH'(i_addr >> 2);
  assign cpu_tag   = TAG_WIDTH'(i_addr >> (INDEX_WIDTH + 2));
  assign cpu_waddr = WordW'(i_addr >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    pend_d  = pend_q;
    case (state_q)
      StSweep: begin
        cnt_d  = cnt_q + 1'b1;
        pend_d = 1'b0;
        if (cnt_q == '1) state_d = StLookup;
      end
      StLookup: begin
        if (i_flush) begin
          cnt_d   = '0;
          state_d = StSweep;
        end else if (i_rd && !i_set_hit) begin
          waddr_d = cpu_waddr;
          state_d = StMem;
        end
      end
      StMem: begin
        // A flush arriving mid-refill is deferred until the line is written.
        pend_d = pend_q | i_flush;
        if (i_mem_ack) begin
          data_d  = i_mem_data;
          state_d = StFill;
        end
      end
      StFill: begin
        if (pend_q || i_flush) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = StSweep;
        end else begin
          state_d = StLookup;
        end
      end
      default: state_d = StSweep;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StSweep;
      cnt_q   <= '0;
      waddr_q <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    o_set_index = cpu_index;
    o_set_tag   = cpu_tag;
    o_set_wr    = 1'b0;
    o_set_cl    = 1'b0;
    o_ready     = 1'b0;
    o_mem_rd    = 1'b0;
    case (state_q)
      StSweep: begin
        o_set_cl    = ~i_reset;
        o_set_index = cnt_q;
      end
      StLookup: o_ready = i_rd & i_set_hit & ~i_flush;
      StMem:    o_mem_rd = 1'b1;
      StFill: begin
        o_set_wr    = 1'b1;
        o_set_index = waddr_q[INDEX_WIDTH-1:0];
        o_set_tag   = waddr_q[WordW-1:INDEX_WIDTH];
      end
      default: ;
    endcase
  end

  assign o_busy     = (state_q != StLookup);
  assign o_data     = i_set_data;
  assign o_set_data = data_q;
  assign o_mem_addr = {waddr_q, 2'b00};

endmodule
